// File: rtl/aes_round_pipe_stage.sv
// aes_round_pipe_stage
// Inter-round pipeline stage for the AES-128 datapath. Carries round state,
// round key and a round-index tag between round units through a two-entry
// skid buffer. in_ready is registered, so there is no combinational path
// from out_ready back to the upstream unit.
//
// state  | meaning
// -------+-------------------------------------------------------------
// EMPTY  | no entry stored; main and skid invalid
// BUSY   | one entry in main, presented on out_*
// FULL   | main presented on out_*, skid holds the next word; in_ready=0
//
// The state encoding is the valid bits themselves: bit0 = main_valid,
// bit1 = skid_valid.

module aes_round_pipe_stage #(
    parameter int DATA_W    = 128,
    parameter int KEY_W     = 128,
    parameter int RND_W     = 4,
    parameter bit ROUND_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_state,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [RND_W-1:0]  in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_state,
    output logic [KEY_W-1:0]  out_key,
    output logic [RND_W-1:0]  out_round,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic main_valid;
    logic skid_valid;
    logic in_xfer;
    logic out_xfer;

    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    logic [DATA_W-1:0] main_state_q;
    logic [KEY_W-1:0]  main_key_q;
    logic [RND_W-1:0]  main_round_q;
    logic [DATA_W-1:0] skid_state_q;
    logic [KEY_W-1:0]  skid_key_q;
    logic [RND_W-1:0]  skid_round_q;

    logic [RND_W-1:0]  cap_round;

    assign main_valid = state_q[0];
    assign skid_valid = state_q[1];

    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_valid & out_ready;

    // The tag is adjusted once, at capture; a skid-to-main move copies it as is.
    generate
        if (ROUND_INC) begin : g_round_inc
            assign cap_round = in_round + RND_W'(1);
        end else begin : g_round_pass
            assign cap_round = in_round;
        end
    endgenerate

    // State register; reset drops both valid bits immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and register-load decisions; flush overrides any transfer.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_BUSY;
                        load_main_in = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_d      = ST_FULL;
                        load_skid_in = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d        = ST_BUSY;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Main data register: loads from the input or from skid; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_state_q <= '0;
            main_key_q   <= '0;
            main_round_q <= '0;
        end else if (load_main_in) begin
            main_state_q <= in_state;
            main_key_q   <= in_key;
            main_round_q <= cap_round;
        end else if (load_main_skid) begin
            main_state_q <= skid_state_q;
            main_key_q   <= skid_key_q;
            main_round_q <= skid_round_q;
        end
    end

    // Skid data register: catches the one word accepted while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_state_q <= '0;
            skid_key_q   <= '0;
            skid_round_q <= '0;
        end else if (load_skid_in) begin
            skid_state_q <= in_state;
            skid_key_q   <= in_key;
            skid_round_q <= cap_round;
        end
    end

    assign out_state = main_state_q;
    assign out_key   = main_key_q;
    assign out_round = main_round_q;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_aes_round_pipe_stage.sv
// Testbench for aes_round_pipe_stage: directed scenarios plus a randomized
// run checked against a FIFO-queue reference model of capacity two.

module tb_aes_round_pipe_stage;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic [3:0]   in_round;
    logic         out_ready;

    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic [1:0]   occupancy;

    logic         in_ready0;
    logic         out_valid0;
    logic [127:0] out_state0;
    logic [127:0] out_key0;
    logic [3:0]   out_round0;
    logic [1:0]   occupancy0;

    int tests_run = 0;
    int fails     = 0;

    // Reference model: a queue of words, capacity two.
    logic [127:0] mq_state[$];
    logic [127:0] mq_key[$];
    logic [3:0]   mq_r1[$];
    logic [3:0]   mq_r0[$];

    aes_round_pipe_stage #(.ROUND_INC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .in_key(in_key), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_key(out_key), .out_round(out_round),
        .occupancy(occupancy)
    );

    aes_round_pipe_stage #(.ROUND_INC(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_state(in_state), .in_key(in_key), .in_round(in_round),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_state(out_state0), .out_key(out_key0), .out_round(out_round0),
        .occupancy(occupancy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        mq_state.delete();
        mq_key.delete();
        mq_r1.delete();
        mq_r0.delete();
    endtask

    // Advance one clock edge and update the model from the inputs in force.
    task automatic tick();
        bit acc;
        bit pop;
        acc = in_valid && (mq_state.size() < 2);
        pop = out_ready && (mq_state.size() > 0);
        @(posedge clk);
        #1;
        if (flush) begin
            model_clear();
        end else begin
            if (pop) begin
                void'(mq_state.pop_front());
                void'(mq_key.pop_front());
                void'(mq_r1.pop_front());
                void'(mq_r0.pop_front());
            end
            if (acc) begin
                mq_state.push_back(in_state);
                mq_key.push_back(in_key);
                mq_r1.push_back(4'((int'(in_round) + 1) % 16));
                mq_r0.push_back(in_round);
            end
        end
    endtask

    task automatic drive_word(input logic [127:0] s, input logic [127:0] k, input logic [3:0] r);
        in_valid = 1'b1;
        in_state = s;
        in_key   = k;
        in_round = r;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests_run++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        tests_run++;
        if (out_state !== 128'h0 || out_key !== 128'h0 || out_round !== 4'h0) begin
            fails++; $display("FAIL reset_data got=%h/%h/%h exp=0", out_state, out_key, out_round);
        end
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [127:0] s[4];
        for (int i = 0; i < 4; i++) s[i] = rand128();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_word(s[i], ~s[i], 4'(i));
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_round !== 4'(i + 1) || out_state !== s[i] || out_key !== ~s[i]) begin
                fails++;
                $display("FAIL stream_word%0d got v=%b r=%h s=%h exp v=1 r=%h s=%h", i, out_valid, out_round, out_state, 4'(i + 1), s[i]);
            end
            tests_run++;
            if (occupancy > 2'd1) begin fails++; $display("FAIL stream_occ%0d got=%0d exp<=1", i, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL stream_empty got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
        end
    endtask

    logic [127:0] word_a;
    logic [127:0] word_b;

    task automatic test_skid_fill();
        word_a    = rand128();
        word_b    = rand128();
        out_ready = 1'b0;
        drive_word(word_a, word_a ^ 128'h5, 4'h2);
        tick();
        drive_word(word_b, word_b ^ 128'h5, 4'h3);
        tick();
        tests_run++;
        if (occupancy !== 2'd2) begin fails++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
        tests_run++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
        tests_run++;
        if (out_state !== word_a || out_round !== 4'h3) begin
            fails++; $display("FAIL skid_head got=%h r=%h exp=%h r=3", out_state, out_round, word_a);
        end
        drive_word(rand128(), rand128(), 4'h9);
        tick();
        tests_run++;
        if (out_state !== word_a || occupancy !== 2'd2 || out_valid !== 1'b1) begin
            fails++; $display("FAIL skid_hold got=%h occ=%0d exp=%h occ=2", out_state, occupancy, word_a);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_state !== word_b || out_key !== (word_b ^ 128'h5) || out_round !== 4'h4) begin
            fails++; $display("FAIL drain_b got=%h r=%h exp=%h r=4", out_state, out_round, word_b);
        end
        tests_run++;
        if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
            fails++; $display("FAIL drain_first got rdy=%b occ=%0d exp rdy=1 occ=1", in_ready, occupancy);
        end
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL drain_empty got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        drive_word(rand128(), rand128(), 4'hF);
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (out_round !== 4'h0) begin fails++; $display("FAIL wrap_inc got=%h exp=0", out_round); end
        tests_run++;
        if (out_round0 !== 4'hF) begin fails++; $display("FAIL wrap_pass got=%h exp=f", out_round0); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_word(rand128(), rand128(), 4'h1);
        tick();
        drive_word(rand128(), rand128(), 4'h2);
        tick();
        tests_run++;
        if (occupancy !== 2'd2) begin fails++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
        flush     = 1'b1;
        out_ready = 1'b1;
        drive_word(rand128(), rand128(), 4'h3);
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_clear got occ=%0d v=%b rdy=%b exp occ=0 v=0 rdy=1", occupancy, out_valid, in_ready);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_no_capture got occ=%0d v=%b exp occ=0 v=0", occupancy, out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_word(rand128(), rand128(), 4'h5);
        tick();
        drive_word(rand128(), rand128(), 4'h6);
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (occupancy !== 2'd2) begin fails++; $display("FAIL arst_pre_occ got=%0d exp=2", occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_state !== 128'h0) begin
            fails++; $display("FAIL arst_immediate got v=%b s=%h exp v=0 s=0", out_valid, out_state);
        end
        tests_run++;
        if (occupancy !== 2'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL arst_occ got occ=%0d rdy=%b exp occ=0 rdy=1", occupancy, in_ready);
        end
        model_clear();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_state  = rand128();
            in_key    = rand128();
            in_round  = 4'($urandom_range(0, 15));
            tick();
            tests_run++;
            if (out_valid !== (mq_state.size() > 0) || occupancy !== 2'(mq_state.size()) || in_ready !== (mq_state.size() < 2)) begin
                fails++;
                $display("FAIL rand_ctrl c=%0d got v=%b occ=%0d rdy=%b exp occ=%0d", c, out_valid, occupancy, in_ready, mq_state.size());
            end
            if (mq_state.size() > 0) begin
                tests_run++;
                if (out_state !== mq_state[0] || out_key !== mq_key[0] || out_round !== mq_r1[0] || out_round0 !== mq_r0[0]) begin
                    fails++;
                    $display("FAIL rand_data c=%0d got s=%h r=%h r0=%h exp s=%h r=%h r0=%h", c, out_state, out_round, out_round0, mq_state[0], mq_r1[0], mq_r0[0]);
                end
            end
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (occupancy !== 2'd0) begin fails++; $display("FAIL rand_drain got occ=%0d exp=0", occupancy); end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_key    = '0;
        in_round  = '0;
        out_ready = 1'b0;
        test_reset();
        test_stream();
        test_skid_fill();
        test_drain();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
